// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says sequence engine.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW_ON,
    SHOW_GAP,
    INPUT,
    WIN,
    LOSE
  } state_t;

  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  // An all-zero Galois LFSR never leaves zero, so a zero seed is swapped for this.
  localparam logic [7:0] LFSR_SEED_SUB = 8'h01;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? LFSR_SEED_SUB : s;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Galois LFSR with synchronous load and advance; reusable by sound-pattern logic.
// Latency: load/advance take effect on the next clock edge.
// Backpressure: none; holds its value when neither load nor advance is asserted.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] state
);

  // Load wins over advance so a reload and a step in the same cycle restart cleanly.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= LFSR_SEED_SUB;
    end else if (load) begin
      state <= seed_fix(seed);
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/simon_seq_check.sv
// Simon Says game engine: plays an LFSR-derived sequence, then checks the player's keys.
// Latency: start or key event acts on the sampling edge; outputs decode the registered state.
// Backpressure: none; keys arriving outside INPUT are ignored, start overrides everything.
module simon_seq_check #(
  parameter int MAX_LEN        = 16,
  parameter int SYM_W          = 2,
  parameter int SHOW_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 50
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic             strobe,
  input  logic [4:0]       code,
  output logic             show_valid,
  output logic [SYM_W-1:0] show_sym,
  output logic             await_key,
  output logic [4:0]       round_len,
  output logic             win,
  output logic             lose
);

  import simon_pkg::*;

  localparam int PH_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PH_W-1:0] SHOW_LAST = PH_W'(SHOW_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_CYCLES - 1);
  localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
  localparam logic [4:0]      MAX_LEN5  = 5'(MAX_LEN);

  state_t            state, state_d;
  logic [PH_W-1:0]   ph_cnt, ph_cnt_d;
  logic [4:0]        idx, idx_d;
  logic [4:0]        len, len_d;
  logic [TO_W-1:0]   tmr, tmr_d;
  logic [7:0]        seed_q;
  logic              strobe_q;

  logic              lfsr_load;
  logic              lfsr_adv;
  logic [7:0]        lfsr_seed;
  logic [7:0]        lfsr;

  logic              key_evt;
  logic              key_ok;
  logic [SYM_W-1:0]  sym;

  // Rising edge of strobe only; strobe_q tracks in every state, so a key
  // already held when INPUT is entered never produces an event.
  assign key_evt = strobe & ~strobe_q;
  assign sym     = lfsr[SYM_W-1:0];
  // Zero-extended symbol compare: codes at or above 2^SYM_W can never match.
  assign key_ok  = (code == 5'(sym));

  simon_lfsr u_lfsr (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (lfsr_load),
    .seed    (lfsr_seed),
    .advance (lfsr_adv),
    .state   (lfsr)
  );

  // State, counters, captured seed and strobe history.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      ph_cnt   <= '0;
      idx      <= '0;
      len      <= '0;
      tmr      <= '0;
      seed_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_d;
      ph_cnt   <= ph_cnt_d;
      idx      <= idx_d;
      len      <= len_d;
      tmr      <= tmr_d;
      strobe_q <= strobe;
      if (start) begin
        seed_q <= seed;
      end
    end
  end

  // Next-state, counter updates and LFSR control; start pre-empts every other event.
  always_comb begin
    state_d   = state;
    ph_cnt_d  = ph_cnt;
    idx_d     = idx;
    len_d     = len;
    tmr_d     = tmr;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    lfsr_seed = seed_q;

    if (start) begin
      state_d   = SHOW_ON;
      ph_cnt_d  = '0;
      idx_d     = '0;
      len_d     = 5'd1;
      tmr_d     = '0;
      lfsr_load = 1'b1;
      lfsr_seed = seed;
    end else begin
      case (state)
        SHOW_ON: begin
          if (ph_cnt == SHOW_LAST) begin
            state_d  = SHOW_GAP;
            ph_cnt_d = '0;
            idx_d    = idx + 5'd1;
            lfsr_adv = 1'b1;
          end else begin
            ph_cnt_d = ph_cnt + PH_ONE;
          end
        end
        SHOW_GAP: begin
          if (ph_cnt == GAP_LAST) begin
            ph_cnt_d = '0;
            if (idx == len) begin
              // Whole sequence shown: rewind the LFSR for checking.
              state_d   = INPUT;
              idx_d     = '0;
              tmr_d     = '0;
              lfsr_load = 1'b1;
            end else begin
              state_d = SHOW_ON;
            end
          end else begin
            ph_cnt_d = ph_cnt + PH_ONE;
          end
        end
        INPUT: begin
          if (key_evt) begin
            if (!key_ok) begin
              state_d = LOSE;
            end else if ((idx + 5'd1) < len) begin
              idx_d    = idx + 5'd1;
              lfsr_adv = 1'b1;
              tmr_d    = '0;
            end else if (len == MAX_LEN5) begin
              state_d = WIN;
            end else begin
              // Round complete: grow by one and replay from the top after a gap.
              state_d   = SHOW_GAP;
              len_d     = len + 5'd1;
              idx_d     = '0;
              ph_cnt_d  = '0;
              lfsr_load = 1'b1;
            end
          end else if (tmr == TO_LAST) begin
            // This idle cycle is the TIMEOUT_CYCLES-th one.
            state_d = LOSE;
          end else begin
            tmr_d = tmr + TO_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode the registered state only, so an async reset clears them at once.
  always_comb begin
    show_valid = 1'b0;
    show_sym   = '0;
    await_key  = 1'b0;
    win        = 1'b0;
    lose       = 1'b0;
    round_len  = (state == IDLE) ? 5'd0 : len;
    case (state)
      SHOW_ON: begin
        show_valid = 1'b1;
        show_sym   = sym;
      end
      INPUT:   await_key = 1'b1;
      WIN:     win       = 1'b1;
      LOSE:    lose      = 1'b1;
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_simon_seq_check.sv
// Self-checking bench for simon_seq_check: table-driven multi-round play with a
// playback scoreboard, plus hand-written sequences for the corner cases.
module tb_simon_seq_check;

  localparam int SHOW_CYCLES = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       strobe = 1'b0;
  logic [4:0] code = 5'd0;

  logic       show_valid, await_key, win, lose;
  logic [1:0] show_sym;
  logic [4:0] round_len;

  logic       d2_show_valid, d2_await_key, d2_win, d2_lose;
  logic [1:0] d2_show_sym;
  logic [4:0] d2_round_len;

  logic [10:0] outs, d2_outs;
  assign outs    = {show_valid, show_sym, await_key, round_len, win, lose};
  assign d2_outs = {d2_show_valid, d2_show_sym, d2_await_key, d2_round_len, d2_win, d2_lose};

  always #5 clk = ~clk;

  simon_seq_check dut (
    .clk(clk), .n_rst(n_rst), .start(start), .seed(seed), .strobe(strobe), .code(code),
    .show_valid(show_valid), .show_sym(show_sym), .await_key(await_key),
    .round_len(round_len), .win(win), .lose(lose)
  );

  simon_seq_check #(.MAX_LEN(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .start(start), .seed(seed), .strobe(strobe), .code(code),
    .show_valid(d2_show_valid), .show_sym(d2_show_sym), .await_key(d2_await_key),
    .round_len(d2_round_len), .win(d2_win), .lose(d2_lose)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic press(input logic [4:0] c);
    strobe = 1'b1;
    code   = c;
    cyc();
    strobe = 1'b0;
    code   = 5'd0;
    cyc();
  endtask

  task automatic wait_await(input string nm);
    int n = 0;
    while (!await_key && n < 400) begin
      cyc();
      n++;
    end
    check(nm, {31'd0, await_key}, 32'd1);
  endtask

  task automatic do_reset();
    start  = 1'b0;
    strobe = 1'b0;
    code   = 5'd0;
    n_rst  = 1'b0;
    cyc();
    check("reset_outs", {21'd0, outs}, 32'd0);
    n_rst = 1'b1;
    cyc();
  endtask

  task automatic pulse_start(input logic [7:0] s);
    seed  = s;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Playback scoreboard: expected symbols are queued before each playback and
  // popped on every rising edge of show_valid; each presentation length is checked.
  logic [1:0] sb[$];
  logic       mon_en = 1'b0;
  logic       prev_sv = 1'b0;
  int         run = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_sv = 1'b0;
      run     = 0;
    end else begin
      if (show_valid && !prev_sv) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_underflow: got symbol %0d, expected no playback", show_sym);
        end else begin
          check("playback_sym", {30'd0, show_sym}, {30'd0, sb.pop_front()});
        end
      end
      if (!show_valid && prev_sv) begin
        check("show_len", run, SHOW_CYCLES);
      end
      run     = show_valid ? run + 1 : 0;
      prev_sv = show_valid;
    end
  end

  typedef struct {
    logic [7:0] seed;
    logic [1:0] syms[5];
  } vec_t;

  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-derived first five symbols of each seed (Galois 0xB8, right shift).
    tbl[0].seed = 8'h01; tbl[0].syms = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3};
    tbl[1].seed = 8'h00; tbl[1].syms = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3};
    tbl[2].seed = 8'hA5; tbl[2].syms = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    tbl[3].seed = 8'hFF; tbl[3].syms = '{2'd3, 2'd3, 2'd3, 2'd1, 2'd2};

    cyc();
    check("por_outs", {21'd0, outs}, 32'd0);

    // Five rounds of correct play per seed, with the scoreboard checking playback.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      mon_en = 1'b1;
      sb.push_back(tbl[v].syms[0]);
      pulse_start(tbl[v].seed);
      check("first_show", {31'd0, show_valid}, 32'd1);
      for (int r = 1; r <= 5; r++) begin
        wait_await("await_round");
        check("sb_drain", sb.size(), 32'd0);
        check("round_len", {27'd0, round_len}, r);
        if (r < 5) begin
          for (int i = 0; i <= r; i++) sb.push_back(tbl[v].syms[i]);
        end
        for (int i = 0; i < r; i++) press({3'd0, tbl[v].syms[i]});
      end
      mon_en = 1'b0;
      check("len_after_r5", {27'd0, round_len}, 32'd6);
      check("gap_after_r5", {31'd0, show_valid}, 32'd0);
    end
    sb.delete();

    // Wrong key in round 2.
    do_reset();
    pulse_start(8'h01);
    wait_await("wk_await1");
    press(5'd1);
    wait_await("wk_await2");
    press(5'd1);
    strobe = 1'b1;
    code   = 5'd3;
    cyc();
    check("wk_lose", {31'd0, lose}, 32'd1);
    check("wk_await_low", {31'd0, await_key}, 32'd0);
    strobe = 1'b0;
    cyc();

    // Key held across INPUT entry is ignored; then an out-of-range code loses.
    do_reset();
    pulse_start(8'h01);
    strobe = 1'b1;
    code   = 5'd1;
    wait_await("held_await");
    cyc(); cyc(); cyc();
    check("held_ignored", {26'd0, await_key, round_len}, {26'd0, 1'b1, 5'd1});
    strobe = 1'b0;
    cyc();
    press(5'd1);
    check("held_then_ok", {26'd0, await_key, round_len}, {26'd0, 1'b0, 5'd2});
    wait_await("inv_await");
    press(5'd9);
    check("invalid_code_lose", {31'd0, lose}, 32'd1);

    // Timeout: 50 idle INPUT cycles, lose on the next sample.
    do_reset();
    pulse_start(8'h01);
    wait_await("to_await");
    for (int k = 0; k < 49; k++) cyc();
    check("to_still_waiting", {30'd0, await_key, lose}, {30'd0, 1'b1, 1'b0});
    cyc();
    check("to_lose", {30'd0, await_key, lose}, {30'd0, 1'b0, 1'b1});

    // A key in cycle 49 restarts the timer.
    do_reset();
    pulse_start(8'h01);
    wait_await("tr_await1");
    press(5'd1);
    wait_await("tr_await2");
    for (int k = 0; k < 48; k++) cyc();
    press(5'd1);
    for (int k = 0; k < 48; k++) cyc();
    check("tr_still_waiting", {30'd0, await_key, lose}, {30'd0, 1'b1, 1'b0});
    cyc();
    check("tr_lose", {30'd0, await_key, lose}, {30'd0, 1'b0, 1'b1});

    // MAX_LEN=2 instance wins after two rounds; default instance moves to round 3.
    do_reset();
    pulse_start(8'h01);
    wait_await("win_await1");
    press(5'd1);
    wait_await("win_await2");
    press(5'd1);
    press(5'd0);
    check("win2_flag", {29'd0, d2_win, d2_lose, d2_await_key}, {29'd0, 3'b100});
    check("win16_len", {26'd0, win, round_len}, {26'd0, 1'b0, 5'd3});
    cyc(); cyc(); cyc();
    check("win2_hold", {31'd0, d2_win}, 32'd1);

    // start and a matching key event in the same cycle: start wins.
    wait_await("sk_await");
    seed   = 8'hFF;
    start  = 1'b1;
    strobe = 1'b1;
    code   = 5'd1;
    cyc();
    start  = 1'b0;
    check("sk_restart", {21'd0, outs}, {21'd0, 1'b1, 2'd3, 1'b0, 5'd1, 1'b0, 1'b0});
    check("sk_win_restart", {30'd0, d2_show_valid, d2_win}, {30'd0, 2'b10});
    strobe = 1'b0;
    cyc();

    // Asynchronous reset mid-SHOW_ON clears outputs without a clock edge.
    check("pre_rst_show", {31'd0, show_valid}, 32'd1);
    #1 n_rst = 1'b0;
    #1;
    check("async_rst_outs", {21'd0, outs}, 32'd0);
    check("async_rst_outs2", {21'd0, d2_outs}, 32'd0);
    cyc();
    n_rst = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
